// File: rtl/syn_frame_streamer_pkg.sv
// Shared definitions for the sync -> FFT receiver path: streamer FSM state
// encodings, default OFDM frame geometry and the I/Q sample width.
package syn_frame_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP_CP = 2'd1,
    ST_PASS    = 2'd2
  } state_e;

  // Default frame geometry, shared with the FFT and frame-count resetter.
  localparam int DEF_FFT_LEN        = 64;
  localparam int DEF_CP_LEN         = 16;
  localparam int DEF_SYMS_PER_FRAME = 4;

  // Width of each of the I and Q sample components.
  localparam int SAMPLE_WIDTH = 16;

  // Terminal count for a segment of n samples; a zero-length segment maps to 0.
  function automatic int term_of(input int n);
    return (n > 0) ? n - 1 : 0;
  endfunction

endpackage

// File: rtl/syn_sample_counter.sv
// Up-counter with synchronous clear, enable and a runtime terminal value.
// 'count' and 'at_term' reflect the value that applies in the current cycle,
// so a clear and a count in the same cycle behave as counting from zero.
module syn_sample_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] count,
  output logic         at_term
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] base;

  // Effective value this cycle and the next value: wrap to 0 at terminal.
  always_comb begin
    base    = clr ? '0 : cnt_q;
    at_term = (base == term_val);
    cnt_d   = base;
    if (en) begin
      cnt_d = at_term ? '0 : base + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = base;

endmodule

// File: rtl/syn_frame_streamer.sv
// Frame streamer: after a sync pulse, drops each symbol's cyclic prefix and
// forwards FFT_LEN useful samples per symbol for SYMS_PER_FRAME symbols.
// Providing_Stream brackets the frame; frame_done pulses as it drops.
// Optional macro SYN_STREAM_TIMEOUT_EN adds a stall watchdog and the
// frame_abort output.
//
// Handshake: a sample is taken whenever input_strobe=1 (no backpressure);
// each forwarded sample appears one cycle later with out_strobe=1, and the
// out_* data/index outputs hold their value while out_strobe=0.
module syn_frame_streamer
  import syn_frame_streamer_pkg::*;
#(
  parameter int DATA_WIDTH     = SAMPLE_WIDTH,
  parameter int FFT_LEN        = DEF_FFT_LEN,
  parameter int CP_LEN         = DEF_CP_LEN,
  parameter int SYMS_PER_FRAME = DEF_SYMS_PER_FRAME,
  parameter int CNT_WIDTH      = 7,
  parameter int SYM_WIDTH      = 3,
  parameter int TIMEOUT_CYC    = 256
) (
  input  logic                  CLK,
  input  logic                  s_RST,
  input  logic                  sync_detect,
  input  logic                  input_strobe,
  input  logic [DATA_WIDTH-1:0] in_re,
  input  logic [DATA_WIDTH-1:0] in_im,
  output logic                  out_strobe,
  output logic [DATA_WIDTH-1:0] out_re,
  output logic [DATA_WIDTH-1:0] out_im,
  output logic [CNT_WIDTH-1:0]  out_sample_idx,
  output logic [SYM_WIDTH-1:0]  out_sym_idx,
  output logic                  out_last,
  output logic                  Providing_Stream,
  output logic                  frame_done
`ifdef SYN_STREAM_TIMEOUT_EN
  ,
  output logic                  frame_abort
`endif
);

  localparam logic [CNT_WIDTH-1:0] FFT_TERM = CNT_WIDTH'(FFT_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CP_TERM  = CNT_WIDTH'(term_of(CP_LEN));
  localparam logic [SYM_WIDTH-1:0] SYM_TERM = SYM_WIDTH'(SYMS_PER_FRAME - 1);
  // State entered at the start of every symbol.
  localparam state_e FIRST_ST = (CP_LEN == 0) ? ST_PASS : ST_SKIP_CP;

  state_e                  state_q, state_d;
  logic                    out_strobe_q, out_strobe_d;
  logic [DATA_WIDTH-1:0]   out_re_q, out_re_d;
  logic [DATA_WIDTH-1:0]   out_im_q, out_im_d;
  logic [CNT_WIDTH-1:0]    idx_q, idx_d;
  logic [SYM_WIDTH-1:0]    sym_q, sym_d;
  logic                    last_q, last_d;
  logic                    ps_q, ps_d;
  logic                    done_q, done_d;
  logic                    pend_q, pend_d;  // last sample forwarded, close frame next
`ifdef SYN_STREAM_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0]      stall_q, stall_d;
  logic                    abort_q, abort_d;
`endif

  // Front-end control: a sync in IDLE makes this cycle's sample the first one.
  logic                    sync_acc;
  state_e                  eff_state;
  logic                    acc;
  logic [CNT_WIDTH-1:0]    smp_term;
  logic [CNT_WIDTH-1:0]    smp_cnt;
  logic                    smp_at_term;
  logic [SYM_WIDTH-1:0]    sym_cnt;
  logic                    sym_at_term;
  logic                    sym_en;

  assign sync_acc  = (state_q == ST_IDLE) && sync_detect;
  assign eff_state = sync_acc ? FIRST_ST : state_q;
  assign acc       = input_strobe && (eff_state != ST_IDLE);
  assign smp_term  = (eff_state == ST_PASS) ? FFT_TERM : CP_TERM;
  assign sym_en    = acc && (eff_state == ST_PASS) && smp_at_term && !sym_at_term;

  syn_sample_counter #(.W(CNT_WIDTH)) u_smp_cnt (
    .clk      (CLK),
    .rst      (s_RST),
    .clr      (sync_acc),
    .en       (acc),
    .term_val (smp_term),
    .count    (smp_cnt),
    .at_term  (smp_at_term)
  );

  syn_sample_counter #(.W(SYM_WIDTH)) u_sym_cnt (
    .clk      (CLK),
    .rst      (s_RST),
    .clr      (sync_acc),
    .en       (sym_en),
    .term_val (SYM_TERM),
    .count    (sym_cnt),
    .at_term  (sym_at_term)
  );

  // Next-state and registered-output logic for the streamer FSM.
  always_comb begin
    state_d      = state_q;
    out_strobe_d = 1'b0;
    out_re_d     = out_re_q;
    out_im_d     = out_im_q;
    idx_d        = idx_q;
    sym_d        = sym_q;
    last_d       = 1'b0;
    ps_d         = pend_q ? 1'b0 : ps_q;
    done_d       = pend_q;
    pend_d       = 1'b0;

    if (sync_acc) begin
      state_d = FIRST_ST;
      ps_d    = 1'b1;
    end

    if (acc) begin
      case (eff_state)
        ST_SKIP_CP: begin
          if (smp_at_term) begin
            state_d = ST_PASS;
          end
        end
        ST_PASS: begin
          out_strobe_d = 1'b1;
          out_re_d     = in_re;
          out_im_d     = in_im;
          idx_d        = smp_cnt;
          sym_d        = sym_cnt;
          if (smp_at_term) begin
            last_d = 1'b1;
            if (sym_at_term) begin
              state_d = ST_IDLE;
              pend_d  = 1'b1;
            end else begin
              state_d = FIRST_ST;
            end
          end
        end
        default: ;
      endcase
    end

`ifdef SYN_STREAM_TIMEOUT_EN
    stall_d = '0;
    abort_d = 1'b0;
    if ((eff_state != ST_IDLE) && !input_strobe) begin
      stall_d = stall_q + 1'b1;
      if (stall_d == STALL_W'(TIMEOUT_CYC)) begin
        state_d = ST_IDLE;
        ps_d    = 1'b0;
        abort_d = 1'b1;
        stall_d = '0;
      end
    end
`endif
  end

  // FSM state and output registers; reset aborts any frame silently.
  always_ff @(posedge CLK) begin
    if (s_RST) begin
      state_q      <= ST_IDLE;
      out_strobe_q <= 1'b0;
      out_re_q     <= '0;
      out_im_q     <= '0;
      idx_q        <= '0;
      sym_q        <= '0;
      last_q       <= 1'b0;
      ps_q         <= 1'b0;
      done_q       <= 1'b0;
      pend_q       <= 1'b0;
`ifdef SYN_STREAM_TIMEOUT_EN
      stall_q      <= '0;
      abort_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      out_strobe_q <= out_strobe_d;
      out_re_q     <= out_re_d;
      out_im_q     <= out_im_d;
      idx_q        <= idx_d;
      sym_q        <= sym_d;
      last_q       <= last_d;
      ps_q         <= ps_d;
      done_q       <= done_d;
      pend_q       <= pend_d;
`ifdef SYN_STREAM_TIMEOUT_EN
      stall_q      <= stall_d;
      abort_q      <= abort_d;
`endif
    end
  end

  assign out_strobe       = out_strobe_q;
  assign out_re           = out_re_q;
  assign out_im           = out_im_q;
  assign out_sample_idx   = idx_q;
  assign out_sym_idx      = sym_q;
  assign out_last         = last_q;
  assign Providing_Stream = ps_q;
  assign frame_done       = done_q;
`ifdef SYN_STREAM_TIMEOUT_EN
  assign frame_abort      = abort_q;
`endif

endmodule

// File: doc/syn_frame_streamer.md
Name: syn_frame_streamer

Overview:
- Sits between the timing-synchronization stage and the FFT / frame-count reset controller in the synchronization + receiver integration.
- On a sync detection it counts incoming strobed I/Q samples, discards each symbol's cyclic prefix and forwards the FFT_LEN useful samples for SYMS_PER_FRAME symbols.
- It drives the Providing_Stream flag that the downstream frame-count resetter consumes, then returns to idle and waits for the next sync.

Parameters:
- DATA_WIDTH, 16, width of each of I and Q samples (two's complement).
- FFT_LEN, 64, useful samples per OFDM symbol.
- CP_LEN, 16, cyclic-prefix samples discarded before each symbol; 0 is legal.
- SYMS_PER_FRAME, 4, OFDM symbols per frame.
- CNT_WIDTH, 7, sample counter width; must hold max(FFT_LEN, CP_LEN)-1.
- SYM_WIDTH, 3, symbol counter width; must hold SYMS_PER_FRAME-1.
- TIMEOUT_CYC, 256, stall limit in clocks (used only with the optional feature).

Ports:
- CLK  in  1  clock, all logic on rising edge.
- s_RST  in  1  synchronous, active-high reset.
- sync_detect  in  1  one-cycle pulse from timing sync marking frame start.
- input_strobe  in  1  sample valid.
- in_re  in  DATA_WIDTH  input I sample.
- in_im  in  DATA_WIDTH  input Q sample.
- out_strobe  out  1  forwarded sample valid.
- out_re  out  DATA_WIDTH  forwarded I sample.
- out_im  out  DATA_WIDTH  forwarded Q sample.
- out_sample_idx  out  CNT_WIDTH  index 0..FFT_LEN-1 of the forwarded sample within its symbol.
- out_sym_idx  out  SYM_WIDTH  symbol index 0..SYMS_PER_FRAME-1 within the frame.
- out_last  out  1  high with the sample at FFT_LEN-1.
- Providing_Stream  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset: state IDLE, all counters 0, all outputs 0. Reset mid-frame aborts immediately with no frame_done.
- States:
  - IDLE: wait for sync.
  - SKIP_CP: discard the cyclic prefix.
  - PASS: forward useful samples.
- IDLE -> sync_detect=1 -> SKIP_CP, or directly PASS if CP_LEN=0. Sample and symbol counters are cleared. The sample strobed in the same cycle as sync_detect is sample 0 of the CP (or of the data when CP_LEN=0).
- SKIP_CP: each strobed sample increments the counter. When the CP_LEN-th sample is accepted: counter <= 0, go to PASS.
- PASS: each strobed sample is forwarded with 1-cycle latency, all outputs registered.
  - out_strobe=1 with out_re/out_im = that sample and out_sample_idx = counter.
  - When sample FFT_LEN-1 is accepted: out_last=1, counter <= 0.
  - If out_sym_idx < SYMS_PER_FRAME-1: increment the symbol counter and go to SKIP_CP (or stay in PASS if CP_LEN=0).
  - Otherwise go to IDLE.
- Cycles without input_strobe: no counting and out_strobe=0. out_re/out_im/idx hold their last value; out_last=0.
- Providing_Stream:
  - Set to 1 in the cycle after sync is accepted.
  - Cleared to 0 in the cycle after the final out_strobe, i.e. it covers the final forwarded sample.
  - frame_done pulses in that same clearing cycle.
- sync_detect outside IDLE is ignored; a frame is never restarted.
- If sync_detect is asserted in the cycle the frame returns to IDLE, it is ignored. A new sync is accepted from the first IDLE cycle.
- Counters never wrap past their terminal values. Compares use equality to the parameter minus 1.

Optional Feature:
- Macro: SYN_STREAM_TIMEOUT_EN.
- With it: a stall counter clears on every input_strobe and increments in SKIP_CP/PASS while input_strobe=0. When it reaches TIMEOUT_CYC:
  - abort to IDLE;
  - Providing_Stream cleared next cycle;
  - extra output frame_abort pulses 1 cycle;
  - frame_done is not asserted.
- Without it: the block waits indefinitely for samples, the frame_abort port does not exist and no stall counter is built.

Decomposition:
- Shared package holds:
  - state encodings ST_IDLE, ST_SKIP_CP, ST_PASS;
  - default FFT_LEN/CP_LEN/SYMS_PER_FRAME constants, which the FFT and resetter stages also use;
  - the I/Q sample width constant.
- One natural sub-module: syn_sample_counter, a parameterised counter with clear, enable, a terminal value input and a terminal-count flag, instantiated for the sample and symbol counters.

Test Plan:
- FFT_LEN=8, CP_LEN=2, SYMS=2, continuous strobe with ramp data 0..19, sync with sample 0:
  - out_strobe carries 2..9 and 12..19;
  - out_last on 9 and 19;
  - Providing_Stream high from cycle 1 through the output of 19;
  - frame_done 1 cycle later.
- Same config, input_strobe toggling 1/0: same 16 outputs in order, out_strobe only 1 cycle after each accepted strobe, and indices never skip.
- CP_LEN=0, FFT_LEN=4, SYMS=3, sync plus 12 samples: all 12 forwarded; out_sym_idx 0,0,0,0,1,...,2; exactly one frame_done.
- Second sync_detect pulse mid-PASS: ignored, with output identical to the first test.
- s_RST at PASS sample 3: all outputs 0 next cycle, no frame_done; a new sync afterwards yields a normal frame.
- With SYN_STREAM_TIMEOUT_EN and TIMEOUT_CYC=16: stop the strobe after 5 PASS samples. After 16 idle clocks frame_abort pulses, Providing_Stream falls, frame_done stays 0, and the next sync is accepted.
